// File: rtl/vector_sub_sched_pkg.sv
// rtl/vector_sub_sched_pkg.sv - shared vector widths, datapath latency and scheduler state type
//
// Purpose: constants and types used by vector_sub_sched, rr_arbiter and vector_sub.
// Ports:   none (package).
package vector_sub_sched_pkg;

  localparam int LANE_W    = 32;
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = LANE_W * NUM_LANES;
  localparam int VSUB_LAT  = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } sched_state_e;

  // Requester-index width; never below one bit so a 2-requester build still has a tag.
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_sub_sched_rr_arbiter.sv
// rtl/vector_sub_sched_rr_arbiter.sv - round-robin arbiter with registered pointer
//
// Purpose: one-hot grant to the first requester at or above ptr (with wrap);
//          ptr moves to granted index + 1 after every grant.
// Ports:   clk, rst (sync, active-high); req (requests); en (grant enable);
//          gnt (one-hot grant), gnt_idx (granted index), gnt_vld (any grant).
module rr_arbiter
  import vector_sub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = tag_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Walk candidates ptr, ptr+1, ... wrapping at NUM_REQ (not at a power of two).
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!gnt_vld && en && req[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    gnt   = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vector_sub_sched_vector_sub.sv
// rtl/vector_sub_sched_vector_sub.sv - pipelined three-lane 32-bit fixed-point subtractor
//
// Purpose: r = a - b per 32-bit lane, LAT cycles from new_data to output_valid.
// Ports:   clk, rst (sync, active-high); new_data, a, b (operands);
//          output_valid, r (result, LAT cycles later).
module vector_sub
  import vector_sub_sched_pkg::*;
#(
  parameter int LAT = VSUB_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_data,
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic             output_valid,
  output logic [VEC_W-1:0] r
);

  logic [LAT-1:0]   vld_q, vld_d;
  logic [VEC_W-1:0] r_q [LAT];
  logic [VEC_W-1:0] r_d [LAT];
  logic [VEC_W-1:0] diff;

  always_comb begin
    diff = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      diff[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] - b[l*LANE_W +: LANE_W];
    end
    vld_d[0] = new_data;
    r_d[0]   = diff;
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      r_d[s]   = r_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) r_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < LAT; s++) r_q[s] <= r_d[s];
    end
  end

  assign output_valid = vld_q[LAT-1];
  assign r            = r_q[LAT-1];

endmodule

// File: rtl/vector_sub_sched.sv
// rtl/vector_sub_sched.sv - round-robin scheduler sharing one vector_sub among requesters
//
// Purpose: grants at most one vector pair per cycle, tags it with the requester
//          index, and returns v1 - v2 to that requester SUB_LAT+1 cycles later.
// Ports:   clk, rst (sync, active-high);
//          req_valid/req_ready/req_v1/req_v2 (per-requester issue, 96-bit slices);
//          hold (stop granting); res_valid (one-hot owner), res_data (shared result);
//          idle (nothing in flight, no grant); err (sticky tag/datapath disagreement).
module vector_sub_sched
  import vector_sub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SUB_LAT = VSUB_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_v1,
  input  logic [NUM_REQ*VEC_W-1:0] req_v2,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [VEC_W-1:0]         res_data,
  output logic                     idle,
  output logic                     err
);

  localparam int IW = tag_w(NUM_REQ);
  localparam int CW = $clog2(SUB_LAT + 2);

  sched_state_e state;
  logic               grant_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               xfer;
  logic [VEC_W-1:0]   v1_sel, v2_sel;
  logic               dp_valid;
  logic [VEC_W-1:0]   dp_r;

  logic [SUB_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]      tag_idx_q [SUB_LAT];
  logic [IW-1:0]      tag_idx_d [SUB_LAT];
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [VEC_W-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      mask_q, mask_d;
  logic               err_q, err_d;
  logic               tail_vld;
  logic [IW-1:0]      tail_idx;

  // State is a decode of hold and the in-flight count, so dropping hold
  // re-enables granting in the same cycle.
  always_comb begin
    state = S_RUN;
    if (hold) state = (cnt_q != '0) ? S_DRAIN : S_HALT;
    grant_en = (state == S_RUN) && !rst;
    idle     = (state == S_HALT) || ((state == S_RUN) && (cnt_q == '0) && !xfer);
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (xfer)
  );

  always_comb begin
    v1_sel = '0;
    v2_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        v1_sel = req_v1[i*VEC_W +: VEC_W];
        v2_sel = req_v2[i*VEC_W +: VEC_W];
      end
    end
  end

  vector_sub #(.LAT(SUB_LAT)) u_vsub (
    .clk          (clk),
    .rst          (rst),
    .new_data     (xfer),
    .a            (v1_sel),
    .b            (v2_sel),
    .output_valid (dp_valid),
    .r            (dp_r)
  );

  always_comb begin
    tag_vld_d[0] = xfer;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < SUB_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    tail_vld    = tag_vld_q[SUB_LAT-1];
    tail_idx    = tag_idx_q[SUB_LAT-1];
    res_valid_d = tail_vld ? (NUM_REQ'(1) << tail_idx) : '0;
    res_data_d  = tail_vld ? dp_r : res_data_q;
    case ({xfer, tail_vld})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Datapath outputs left over from before a reset are ignored for one latency window.
    mask_d = (mask_q != '0) ? mask_q - CW'(1) : '0;
    err_d  = err_q | ((dp_valid != tail_vld) && (mask_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q   <= '0;
      for (int s = 0; s < SUB_LAT; s++) tag_idx_q[s] <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      cnt_q       <= '0;
      mask_q      <= CW'(SUB_LAT);
      err_q       <= 1'b0;
    end else begin
      tag_vld_q   <= tag_vld_d;
      for (int s = 0; s < SUB_LAT; s++) tag_idx_q[s] <= tag_idx_d[s];
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = gnt;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vector_sub_sched.sv
// tb/tb_vector_sub_sched.sv - self-checking bench for vector_sub_sched
module tb_vector_sub_sched;

  localparam int NUM_REQ = 4;
  localparam int VW      = 96;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*VW-1:0] req_v1;
  logic [NUM_REQ*VW-1:0] req_v2;
  logic                  hold;
  logic [NUM_REQ-1:0]    res_valid;
  logic [VW-1:0]         res_data;
  logic                  idle;
  logic                  err;

  vector_sub_sched #(.NUM_REQ(NUM_REQ), .SUB_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_v1    (req_v1),
    .req_v2    (req_v2),
    .hold      (hold),
    .res_valid (res_valid),
    .res_data  (res_data),
    .idle      (idle),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] lane_sub(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int l = 0; l < 3; l++) r[l*32 +: 32] = a[l*32 +: 32] - b[l*32 +: 32];
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < 3; l++) begin
      case ($urandom_range(0, 3))
        0:       v[l*32 +: 32] = 32'h0000_0000;
        1:       v[l*32 +: 32] = 32'hFFFF_FFFF;
        2:       v[l*32 +: 32] = 32'h8000_0000;
        default: v[l*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Behavioural model: a list of outstanding results, each due three cycles after its grant.
  typedef struct {
    int            due;
    int            idx;
    logic [VW-1:0] data;
  } op_t;

  op_t  pend_q[$];
  int   cyc       = 0;
  int   ptr_m     = 0;
  logic err_m     = 1'b0;
  int   last_gidx = -1;
  logic inject    = 1'b0;

  always @(negedge clk) begin
    int            gidx;
    logic [NUM_REQ-1:0] exp_rv;
    logic [VW-1:0] exp_rd;
    cyc++;
    if (rst) begin
      chk("req_ready_in_reset", VW'(req_ready), '0);
      pend_q.delete();
      ptr_m     = 0;
      err_m     = 1'b0;
      last_gidx = -1;
    end else begin
      gidx = -1;
      if (!hold) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (gidx < 0 && req_valid[(ptr_m + k) % NUM_REQ]) gidx = (ptr_m + k) % NUM_REQ;
        end
      end
      chk("ptr", VW'(dut.u_arb.ptr_q), VW'(ptr_m));
      chk("req_ready", VW'(req_ready), (gidx >= 0) ? (VW'(1) << gidx) : '0);
      exp_rv = '0;
      exp_rd = '0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        exp_rv = NUM_REQ'(1) << pend_q[0].idx;
        exp_rd = pend_q[0].data;
        void'(pend_q.pop_front());
        chk("res_data", res_data, exp_rd);
      end
      chk("res_valid", VW'(res_valid), VW'(exp_rv));
      chk("idle", VW'(idle), VW'((pend_q.size() == 0) && (gidx < 0)));
      chk("err", VW'(err), VW'(err_m));
      if (inject) err_m = 1'b1;
      if (gidx >= 0) begin
        pend_q.push_back('{cyc + 3, gidx,
                           lane_sub(req_v1[gidx*VW +: VW], req_v2[gidx*VW +: VW])});
        ptr_m = (gidx + 1) % NUM_REQ;
      end
      last_gidx = gidx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_v1    = '0;
    req_v2    = '0;
    hold      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_res_valid", VW'(res_valid), '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_err", VW'(err), '0);
    chk("rst_idle", VW'(idle), VW'(1));
    chk("rst_ptr", VW'(dut.u_arb.ptr_q), '0);

    // Fairness: all four requesting for eight cycles from reset
    tick();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_v1[i*VW +: VW] = rnd_vec();
      req_v2[i*VW +: VW] = rnd_vec();
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", VW'(req_ready), VW'(1) << (k % 4));
      chk("fair_idle", VW'(idle), '0);
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // Single operation from requester 2
    do_reset();
    req_v1[2*VW +: VW] = 96'h00030000_00050000_00000000;
    req_v2[2*VW +: VW] = 96'h00010000_00020000_00010000;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_grant", VW'(req_ready), VW'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    chk("single_res_valid", VW'(res_valid), VW'(4'b0100));
    chk("single_res_data", res_data, 96'h00020000_00030000_FFFF0000);
    repeat (3) tick();

    // Drain with two operations in flight and requester 2 waiting
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_v1[i*VW +: VW] = rnd_vec();
      req_v2[i*VW +: VW] = rnd_vec();
    end
    req_valid = 4'b0111;
    @(negedge clk);
    chk("drain_g0", VW'(req_ready), VW'(4'b0001));
    tick();
    req_valid = 4'b0110;
    @(negedge clk);
    chk("drain_g1", VW'(req_ready), VW'(4'b0010));
    tick();
    req_valid = 4'b0100;
    hold      = 1'b1;
    @(negedge clk);
    chk("drain_hold_ready", VW'(req_ready), '0);
    chk("drain_busy", VW'(idle), '0);
    tick();
    @(negedge clk);
    chk("drain_hold_ready2", VW'(req_ready), '0);
    tick();
    @(negedge clk);
    chk("drain_idle", VW'(idle), VW'(1));
    chk("drain_hold_ready3", VW'(req_ready), '0);
    tick();
    hold = 1'b0;
    @(negedge clk);
    chk("drain_regrant", VW'(req_ready), VW'(4'b0100));
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset one cycle after two transfers
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rmid_g0", VW'(req_ready), VW'(4'b0001));
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rmid_first_grant", VW'(req_ready), VW'(4'b0001));
    chk("rmid_ptr", VW'(dut.u_arb.ptr_q), '0);
    chk("rmid_no_res0", VW'(res_valid), '0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rmid_no_res1", VW'(res_valid), '0);
    repeat (4) tick();
    chk("rmid_err", VW'(err), '0);

    // Error detection: spurious datapath valid with no tag
    do_reset();
    repeat (3) tick();
    force dut.dp_valid = 1'b1;
    inject = 1'b1;
    tick();
    release dut.dp_valid;
    inject = 1'b0;
    @(negedge clk);
    chk("err_set", VW'(err), VW'(1));
    tick();
    tick();
    @(negedge clk);
    chk("err_sticky", VW'(err), VW'(1));
    tick();
    do_reset();
    @(negedge clk);
    chk("err_cleared", VW'(err), '0);
    tick();

    // Sparse traffic from requester 3 only
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_v1[3*VW +: VW] = rnd_vec();
      req_v2[3*VW +: VW] = rnd_vec();
      req_valid = 4'b1000;
      @(negedge clk);
      chk("sparse_grant", VW'(req_ready), VW'(4'b1000));
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("sparse_ptr", VW'(dut.u_arb.ptr_q), '0);
      tick();
    end

    // Randomized traffic; a requester keeps its request and data until granted
    for (int t = 0; t < 400; t++) begin
      if (last_gidx >= 0) req_valid[last_gidx] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]       = 1'b1;
          req_v1[i*VW +: VW] = rnd_vec();
          req_v2[i*VW +: VW] = rnd_vec();
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      tick();
    end
    req_valid = '0;
    hold      = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sub_sched.md
# vector_sub_sched

Round-robin scheduler that shares one pipelined `vector_sub` datapath among `NUM_REQ` requesters in the ray-tracing pipeline. It accepts at most one 96-bit vector pair per cycle, tags each accepted operation with its requester index, and returns each difference to its originator.
- **Requesters:** ray-generation, intersection and shading units.
- **Datapath:** three 32-bit fixed-point lanes, latency 2.
- **Ordering:** results return in issue order.
- **Drain control:** a `hold` input lets the frame controller drain the unit cleanly.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `SUB_LAT`, default 2: `vector_sub` latency, from `new_data` to `output_valid`.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  one-hot grant; combinational from `req_valid`, `hold` and the registered RR pointer.
- `req_v1`  in  NUM_REQ*96  minuends; requester i uses bits [96*i+:96].
- `req_v2`  in  NUM_REQ*96  subtrahends, same packing.
- `hold`  in  1  stop granting new operations; in-flight operations complete.
- `res_valid`  out  NUM_REQ  one-hot; the result belongs to requester i.
- `res_data`  out  96  result `v1 - v2`, shared by all requesters.
- `idle`  out  1  no operation in flight and no grant this cycle.
- `err`  out  1  sticky; datapath `output_valid` disagreed with the tag pipeline.

## Operation
**Arbitration**
- Round-robin pointer `ptr` (0..NUM_REQ-1).
- Grant goes to the first i with `req_valid[i]`, searching from `ptr` upward with wrap.
- No grant while `hold`=1.
- A transfer occurs when `req_valid[i] & req_ready[i]`. After a transfer, `ptr` becomes (granted index + 1) mod NUM_REQ; otherwise `ptr` is unchanged.

**Issue**
- On transfer, drive `vector_sub` with `new_data`=1 and the granted v1/v2 slices.
- Push tag {valid=1, idx} into a SUB_LAT-deep tag shift register.
- Push {0, x} when there is no transfer.

**Return**
- When the tag register's tail is valid, register `res_data` from the datapath `r` and set `res_valid[idx]`=1 for one cycle.
- Datapath `output_valid` must equal the tail valid bit every cycle. A mismatch sets `err`, which clears only on `rst`.

**States**
- RUN: granting allowed; enter on `hold`=0.
- DRAIN: `hold`=1 and in-flight count > 0; no grants.
- HALT: `hold`=1 and in-flight count 0; `idle`=1.
- From DRAIN or HALT, `hold`=0 returns to RUN the same cycle (combinational grant).

**Counters**
- The in-flight counter is width clog2(SUB_LAT+2).
- It increments on transfer and decrements on result. Both in the same cycle leave it unchanged.

**Arithmetic**
- Per-lane 32-bit fixed-point subtract, performed entirely by `vector_sub`. The scheduler never modifies data.

## Timing
- **Reset values:** `req_ready`=0 (forced while `rst`), `res_valid`=0, `res_data`=0, `err`=0, `idle`=1, `ptr`=0, tags invalid, counter 0, state RUN.
- **Reset mid-operation:** in-flight operations are discarded. No `res_valid` appears for them after reset deasserts, and the datapath `output_valid` that follows is ignored for one SUB_LAT window (no `err`).
- **Latency:** transfer at cycle N gives `res_valid` at cycle N+SUB_LAT+1 (N+3 by default).
- **Throughput:** one operation per cycle, with no bubbles under continuous requests.
- **No backpressure on results:** requesters must accept `res_valid` unconditionally.
- **Requester obligation:** a requester must hold `req_valid` and its data stable until granted.
- **`hold` timing:** `hold` asserted in cycle N blocks the grant in cycle N itself.

## Structure
**Shared header (`vec_defs`):**
- LANE_W=32, VEC_W=96, VSUB_LAT=2.
- Tag width clog2(NUM_REQ).

**Sub-module `rr_arbiter`:**
- Parameterised on NUM_REQ.
- Ports: request, enable, one-hot grant, registered pointer update.
- Reused later for sharing the dot-product and cross-product units.

**Top level:** instantiates one `vector_sub` and one `rr_arbiter`.

## Test plan
- **Single operation:** requester 2 sends v1={0x00030000,0x00050000,0x00000000}, v2={0x00010000,0x00020000,0x00010000}, transfer at cycle 10. Expect `res_valid`=4'b0100 at cycle 13 and `res_data`={0x00020000,0x00030000,0xFFFF0000}.
- **Fairness:** all four `req_valid` held high for 8 cycles from reset. Expect grant order 0,1,2,3,0,1,2,3; eight results back-to-back in the same order; `idle`=0 throughout.
- **Drain:** `hold` raised with 2 operations in flight. Expect no `req_ready`, both results delivered, `idle`=1 two cycles later; dropping `hold` re-grants the pending requester the same cycle.
- **Reset mid-flight:** `rst` pulsed 1 cycle after 2 transfers. Expect no `res_valid` afterwards, `err`=0, `ptr`=0, and requester 0 granted first.
- **Error detection:** force datapath `output_valid` high for one cycle with no tag. Expect `err`=1 from the next cycle, remaining set until `rst`.
- **Sparse traffic:** only requester 3 requests, every other cycle. Expect each request granted immediately and `ptr` back at 0 after each grant.
